// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor / BTB slice.
// Holds the sweep FSM encoding, counter reset/allocate values and PC field extraction.
package bp_pkg;

    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_SWEEP = 1'b1
    } bp_state_e;

    // Weakly-not-taken: value written on reset and flush.
    function automatic int ctr_wnt(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    // Weakly-taken: value written when a new entry is allocated.
    function automatic int ctr_wt(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w,
                                           input int tag_bits);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-state logic for the direction predictor.
module bp_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                inc,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    always_comb begin
        ctr_nxt = ctr;
        if (inc) begin
            if (ctr != CTR_MAX) ctr_nxt = ctr + 1'b1;
        end else begin
            if (ctr != '0) ctr_nxt = ctr - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters, a flush sweep
// FSM and a saturating mispredict counter.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_pred_hit,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_valid,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic            i_upd_uncond,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic            i_upd_mispredict,
    output logic            o_upd_misaligned,
    input  logic            i_flush_req,
    output logic            o_busy,
    output logic [15:0]     o_mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(ctr_wt(CTR_BITS));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic                uncond_q [ENTRIES];

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0]    lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit, up_en, up_aligned;
    logic [CTR_BITS-1:0] ctr_nxt;

    assign lk_idx = IDX_W'(pc_index(64'(i_lookup_pc), IDX_W));
    assign lk_tag = TAG_BITS'(pc_tag(64'(i_lookup_pc), IDX_W, TAG_BITS));
    assign up_idx = IDX_W'(pc_index(64'(i_upd_pc), IDX_W));
    assign up_tag = TAG_BITS'(pc_tag(64'(i_upd_pc), IDX_W, TAG_BITS));

    // Lookups are suppressed while the sweep has only partially cleared the table.
    assign lk_hit        = (state_q == BP_IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign o_pred_hit    = lk_hit;
    assign o_pred_taken  = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx] >= WT);
    assign o_pred_target = lk_hit ? target_q[lk_idx] : '0;
    assign o_busy        = (state_q == BP_SWEEP);

    assign up_aligned = (i_upd_target[1:0] == 2'b00);
    assign up_en      = i_upd_valid && (state_q == BP_IDLE) && up_aligned;
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_ctr #(
        .CTR_BITS(CTR_BITS)
    ) u_sat_ctr (
        .ctr    (ctr_q[up_idx]),
        .inc    (i_upd_taken),
        .ctr_nxt(ctr_nxt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = '0;
        case (state_q)
            BP_IDLE: begin
                if (i_flush_req) state_d = BP_SWEEP;
            end
            BP_SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) state_d = BP_IDLE;
            end
            default: state_d = BP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BP_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep and update never overlap: updates are only accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
                uncond_q[i] <= 1'b0;
            end
        end else if (state_q == BP_SWEEP) begin
            valid_q[ptr_q] <= 1'b0;
            ctr_q[ptr_q]   <= WNT;
        end else if (up_en) begin
            if (up_hit) begin
                ctr_q[up_idx]    <= ctr_nxt;
                uncond_q[up_idx] <= i_upd_uncond;
                if (i_upd_taken) target_q[up_idx] <= i_upd_target;
            end else if (i_upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= i_upd_target;
                ctr_q[up_idx]    <= WT;
                uncond_q[up_idx] <= i_upd_uncond;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_upd_misaligned <= 1'b0;
            o_mispredict_cnt <= '0;
        end else begin
            o_upd_misaligned <= i_upd_valid && !up_aligned;
            if (i_upd_valid && i_upd_mispredict && (o_mispredict_cnt != 16'hFFFF))
                o_mispredict_cnt <= o_mispredict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb (default parameters) with a reference table model.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_lookup_pc = '0;
    logic        o_pred_hit, o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_valid = 1'b0;
    logic [31:0] i_upd_pc = '0;
    logic        i_upd_taken = 1'b0;
    logic        i_upd_uncond = 1'b0;
    logic [31:0] i_upd_target = '0;
    logic        i_upd_mispredict = 1'b0;
    logic        o_upd_misaligned;
    logic        i_flush_req = 1'b0;
    logic        o_busy;
    logic [15:0] o_mispredict_cnt;

    branch_predictor_btb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lookup_pc     (i_lookup_pc),
        .o_pred_hit      (o_pred_hit),
        .o_pred_taken    (o_pred_taken),
        .o_pred_target   (o_pred_target),
        .i_upd_valid     (i_upd_valid),
        .i_upd_pc        (i_upd_pc),
        .i_upd_taken     (i_upd_taken),
        .i_upd_uncond    (i_upd_uncond),
        .i_upd_target    (i_upd_target),
        .i_upd_mispredict(i_upd_mispredict),
        .o_upd_misaligned(o_upd_misaligned),
        .i_flush_req     (i_flush_req),
        .o_busy          (o_busy),
        .o_mispredict_cnt(o_mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
    } pred_t;

    pred_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model: ENTRIES=16, CTR_BITS=2, TAG_BITS=8.
    logic        m_valid  [16];
    logic [7:0]  m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    logic        m_uncond [16];
    logic        m_sweeping = 1'b0;
    int          m_cnt = 0;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0;
            m_ctr[i] = 1; m_uncond[i] = 1'b0;
        end
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic tk,
                                         input logic un, input logic [31:0] tgt);
        int i;
        logic [7:0] t;
        i = int'((pc >> 2) & 32'hF);
        t = pc[13:6];
        if (tgt[1:0] != 2'b00) return;
        if (m_valid[i] && m_tag[i] == t) begin
            if (tk) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            m_uncond[i] = un;
            if (tk) m_target[i] = tgt;
        end else if (tk) begin
            m_valid[i] = 1'b1; m_tag[i] = t; m_target[i] = tgt;
            m_ctr[i] = 2; m_uncond[i] = un;
        end
    endfunction

    // Called #1 after a rising edge; drives a lookup, queues the model's answer and checks it.
    task automatic lookup(input logic [31:0] pc);
        pred_t e, got;
        int i;
        i = int'((pc >> 2) & 32'hF);
        i_lookup_pc = pc;
        e.pc = pc;
        e.hit = !m_sweeping && m_valid[i] && (m_tag[i] == pc[13:6]);
        e.taken = e.hit && (m_uncond[i] || m_ctr[i] >= 2);
        e.target = e.hit ? m_target[i] : 32'h0;
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (o_pred_hit !== got.hit || o_pred_taken !== got.taken || o_pred_target !== got.target) begin
            errors++;
            $display("FAIL lookup pc=%h: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                     got.pc, o_pred_hit, o_pred_taken, o_pred_target, got.hit, got.taken, got.target);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic un,
                       input logic [31:0] tgt, input logic mp);
        i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_taken = tk; i_upd_uncond = un;
        i_upd_target = tgt; i_upd_mispredict = mp;
        @(posedge clk);
        model_update(pc, tk, un, tgt);
        if (mp && m_cnt < 16'hFFFF) m_cnt++;
        #1;
        i_upd_valid = 1'b0; i_upd_mispredict = 1'b0;
        checks++;
        if (o_upd_misaligned !== (tgt[1:0] != 2'b00) || o_mispredict_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL upd pc=%h: got misaligned=%b cnt=%0d, want misaligned=%b cnt=%0d",
                     pc, o_upd_misaligned, o_mispredict_cnt, (tgt[1:0] != 2'b00), m_cnt);
        end
    endtask

    task automatic test_reset();
        lookup(32'h40);
        checks++;
        if (o_busy !== 1'b0 || o_mispredict_cnt !== 16'd0 || o_upd_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b cnt=%0d mis=%b, want 0 0 0",
                     o_busy, o_mispredict_cnt, o_upd_misaligned);
        end
    endtask

    task automatic test_basic_update();
        // Same-cycle lookup must see the old (empty) entry.
        i_lookup_pc = 32'h40;
        i_upd_valid = 1'b1; i_upd_pc = 32'h40; i_upd_taken = 1'b1;
        i_upd_target = 32'h100;
        #1;
        checks++;
        if (o_pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: got hit=%b, want 0", o_pred_hit);
        end
        i_upd_valid = 1'b0;
        upd(32'h40, 1'b1, 1'b0, 32'h100, 1'b1);
        lookup(32'h40);
        upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(32'h40);
        upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
        lookup(32'h40);
    endtask

    task automatic test_alias();
        upd(32'h40, 1'b1, 1'b0, 32'h200, 1'b0);
        lookup(32'h40);
        upd(32'h440, 1'b1, 1'b0, 32'h300, 1'b0);
        lookup(32'h40);
        lookup(32'h440);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 6; k++) upd(32'h80, 1'b1, 1'b0, 32'h880, 1'b0);
        upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(32'h80);
        for (int k = 0; k < 4; k++) upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(32'h80);
        upd(32'h80, 1'b1, 1'b0, 32'h990, 1'b0);
        lookup(32'h80);
        upd(32'h84, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(32'h84);
    endtask

    task automatic test_uncond();
        upd(32'hC0, 1'b1, 1'b0, 32'h500, 1'b0);
        upd(32'hC0, 1'b0, 1'b1, 32'h0, 1'b0);
        upd(32'hC0, 1'b0, 1'b1, 32'h0, 1'b0);
        lookup(32'hC0);
    endtask

    task automatic test_misaligned();
        upd(32'h100, 1'b1, 1'b0, 32'h102, 1'b1);
        lookup(32'h100);
        @(posedge clk); #1;
        checks++;
        if (o_upd_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_pulse_width: got %b, want 0", o_upd_misaligned);
        end
    endtask

    task automatic test_flush();
        int busy_cnt, guard;
        for (int k = 0; k < 16; k++) upd(32'h1000 + 32'(k * 4), 1'b1, 1'b0, 32'h4000 + 32'(k * 16), 1'b0);
        lookup(32'h1000);
        lookup(32'h103C);
        i_flush_req = 1'b1;
        @(posedge clk); #1;
        model_reset();
        m_sweeping = 1'b1;
        busy_cnt = 0;
        guard = 0;
        while (o_busy === 1'b1 && guard < 64) begin
            busy_cnt++;
            if (busy_cnt == 1) lookup(32'h103C);
            if (busy_cnt == 3) i_flush_req = 1'b0;
            if (busy_cnt == 5) begin
                i_upd_valid = 1'b1; i_upd_pc = 32'h2000; i_upd_taken = 1'b1;
                i_upd_uncond = 1'b0; i_upd_target = 32'h700; i_upd_mispredict = 1'b1;
                m_cnt++;
            end
            if (busy_cnt == 6) begin
                i_upd_valid = 1'b0; i_upd_mispredict = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        i_flush_req = 1'b0;
        m_sweeping = 1'b0;
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL flush_busy_cycles: got %0d, want 16", busy_cnt);
        end
        checks++;
        if (o_mispredict_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL sweep_mispredict_cnt: got %0d, want %0d", o_mispredict_cnt, m_cnt);
        end
        for (int k = 0; k < 16; k++) lookup(32'h1000 + 32'(k * 4));
        lookup(32'h2000);
        upd(32'h1010, 1'b1, 1'b0, 32'h880, 1'b0);
        lookup(32'h1010);
    endtask

    task automatic test_cnt_saturate();
        i_upd_valid = 1'b1; i_upd_pc = 32'h3000; i_upd_taken = 1'b0;
        i_upd_uncond = 1'b0; i_upd_target = 32'h0; i_upd_mispredict = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        i_upd_valid = 1'b0; i_upd_mispredict = 1'b0;
        checks++;
        if (o_mispredict_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h, want ffff", o_mispredict_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (o_mispredict_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_hold: got %h, want ffff", o_mispredict_cnt);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic_update();
        test_alias();
        test_saturation();
        test_uncond();
        test_misaligned();
        test_flush();
        test_cnt_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
